uart_rom_loader: RTL and testbench



---
 rtl/uart_rom_loader.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rom_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rom_loader.sv
// UART-to-hack_soc ROM loader: receives a word count plus 16-bit words (high byte first) and hands them over with a 4-phase sck/ack strobe.
// Define UART_LOADER_CHECKSUM_EN to expect a trailing XOR byte covering both count bytes and every word byte.
module uart_rom_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 16,
    parameter int ACK_TIMEOUT  = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  uart_rx,
    input  logic                  rom_loader_ack,
    output logic                  rom_loader_load,
    output logic                  rom_loader_sck,
    output logic [DATA_WIDTH-1:0] rom_loader_data,
    output logic                  done_loading,
    output logic                  busy,
    output logic                  error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW-1:0] ACK_MAX  = AW'(ACK_TIMEOUT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [3:0] {
        IDLE, CNT_HI, CNT_LO, W_HI, W_LO, STROBE, RELEASE, DONE, ERR
`ifdef UART_LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LAST = CHK;
`else
    localparam state_t AFTER_LAST = DONE;
`endif

    logic            rx_meta, rx_sync, rx_prev;
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_tick, rx_byte_done, rx_frame_err;

    state_t          state, state_next;
    logic [7:0]      byte_buf, cnt_hi, word_hi;
    logic            byte_valid, byte_take, wants_byte, session, overrun;
    logic [15:0]     remaining;
    logic [15:0]     data_reg;
    logic [AW-1:0]   ack_cnt;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]      checksum;
`endif

    // rx_prev is the third stage, used only to spot the falling edge of the start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        rx_next      = rx_state;
        rx_tick      = (rx_state == RX_START) ? (rx_cnt == HALF_CNT) : (rx_cnt == FULL_CNT);
        rx_byte_done = 1'b0;
        rx_frame_err = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    rx_next      = RX_IDLE;
                    rx_byte_done = rx_sync;
                    rx_frame_err = !rx_sync;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    // rx_bit wraps back to zero after the eighth data bit, so it needs no explicit clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
            if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    assign session   = (state != IDLE) && (state != DONE) && (state != ERR);
    assign byte_take = wants_byte && byte_valid;
    assign overrun   = rx_byte_done && byte_valid && !byte_take;

    always_comb begin
        state_next = state;
        wants_byte = 1'b0;
        case (state)
            IDLE:    if (run) state_next = CNT_HI;
            CNT_HI: begin
                wants_byte = 1'b1;
                if (byte_valid) state_next = CNT_LO;
            end
            CNT_LO: begin
                wants_byte = 1'b1;
                if (byte_valid) state_next = ({cnt_hi, byte_buf} == 16'd0) ? AFTER_LAST : W_HI;
            end
            W_HI: begin
                wants_byte = 1'b1;
                if (byte_valid) state_next = W_LO;
            end
            W_LO: begin
                wants_byte = 1'b1;
                if (byte_valid) state_next = STROBE;
            end
            STROBE: begin
                if (rom_loader_ack)          state_next = RELEASE;
                else if (ack_cnt == ACK_MAX) state_next = ERR;
            end
            RELEASE: begin
                if (!rom_loader_ack)         state_next = (remaining == 16'd1) ? AFTER_LAST : W_HI;
                else if (ack_cnt == ACK_MAX) state_next = ERR;
            end
`ifdef UART_LOADER_CHECKSUM_EN
            CHK: begin
                wants_byte = 1'b1;
                if (byte_valid) state_next = (byte_buf == checksum) ? DONE : ERR;
            end
`endif
            DONE, ERR: if (!run) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        // Dropping run wins over any error raised in the same cycle
        if (session) begin
            if (!run)                          state_next = IDLE;
            else if (rx_frame_err || overrun)  state_next = ERR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // The ack watchdog restarts on every state change, so each handshake phase gets its own budget
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_buf   <= '0;
            byte_valid <= 1'b0;
            cnt_hi     <= '0;
            word_hi    <= '0;
            remaining  <= '0;
            data_reg   <= '0;
            ack_cnt    <= '0;
        end else begin
            if (!session) begin
                byte_valid <= 1'b0;
            end else if (rx_byte_done) begin
                byte_buf   <= rx_shift;
                byte_valid <= 1'b1;
            end else if (byte_take) begin
                byte_valid <= 1'b0;
            end
            ack_cnt <= (state_next != state) ? '0 : ack_cnt + 1'b1;
            if (byte_take) begin
                case (state)
                    CNT_HI:  cnt_hi    <= byte_buf;
                    CNT_LO:  remaining <= {cnt_hi, byte_buf};
                    W_HI:    word_hi   <= byte_buf;
                    W_LO:    if (state_next == STROBE) data_reg <= {word_hi, byte_buf};
                    default: ;
                endcase
            end
            if (state == RELEASE && !rom_loader_ack) remaining <= remaining - 16'd1;
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       checksum <= '0;
        else if (state == IDLE)             checksum <= '0;
        else if (byte_take && state != CHK) checksum <= checksum ^ byte_buf;
    end
`endif

    assign rom_loader_load = session;
    assign busy            = session;
    assign rom_loader_sck  = (state == STROBE);
    assign done_loading    = (state == DONE);
    assign error           = (state == ERR);
    assign rom_loader_data = data_reg;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Bench for uart_rom_loader: serial byte driver, 3-cycle ack responder and a word-queue model of the expected strobes.
// Build with UART_LOADER_CHECKSUM_EN to append checksum bytes and run the checksum scenarios.
module tb_uart_rom_loader;

    localparam int CPB    = 8;
    localparam int ACK_TO = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        uart_rx = 1'b1;
    logic        rom_loader_ack = 1'b0;
    logic        rom_loader_load, rom_loader_sck, done_loading, busy, error;
    logic [15:0] rom_loader_data;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          strobes = 0;
    int          sck_rise_cyc = 0;
    int          err_rise_cyc = 0;
    logic        ack_enable = 1'b1;
    logic [7:0]  tx_q[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rom_loader #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (16),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .run            (run),
        .uart_rx        (uart_rx),
        .rom_loader_ack (rom_loader_ack),
        .rom_loader_load(rom_loader_load),
        .rom_loader_sck (rom_loader_sck),
        .rom_loader_data(rom_loader_data),
        .done_loading   (done_loading),
        .busy           (busy),
        .error          (error)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic applyStimulus(input int bad_idx, input int count);
        for (int k = 0; k < count; k++) sendByte(tx_q[k], (k == bad_idx) ? 1'b0 : 1'b1);
    endtask

    // Model: the words the loader must strobe, parsed from the first 'good' bytes of the stream
    task automatic expectWords(input int good);
        int n;
        exp_q.delete();
        if (good >= 2) begin
            n = int'({tx_q[0], tx_q[1]});
            for (int w = 0; w < n && (3 + 2 * w) < good; w++)
                exp_q.push_back({tx_q[2 + 2 * w], tx_q[3 + 2 * w]});
        end
    endtask

    task automatic appendChecksum();
`ifdef UART_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (tx_q[k]) x = x ^ tx_q[k];
        tx_q.push_back(x);
`endif
    endtask

    // sel: 0 waits for done_loading, 1 for error, 2 for sck
    task automatic waitFor(input string name, input int sel, input int budget);
        int n;
        n = 0;
        while (!(sel == 0 ? done_loading : (sel == 1 ? error : rom_loader_sck)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: no response within %0d cycles, required one", name, budget);
        end
    endtask

    initial begin : ack_responder
        int lag;
        lag = 0;
        forever begin
            @(negedge clk);
            if (ack_enable && rom_loader_sck != rom_loader_ack) begin
                lag++;
                if (lag >= 3) begin
                    rom_loader_ack = rom_loader_sck;
                    lag = 0;
                end
            end else begin
                lag = 0;
            end
        end
    end

    initial begin : compare
        logic        sck_prev, err_prev;
        logic [15:0] data_prev;
        sck_prev  = 1'b0;
        err_prev  = 1'b0;
        data_prev = 16'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n) begin
                checkOutput("busy_eq_load", busy, rom_loader_load);
                if (error)          checkOutput("error_quiet", {rom_loader_load, rom_loader_sck, done_loading}, 3'b000);
                if (done_loading)   checkOutput("done_quiet", {rom_loader_load, rom_loader_sck, error}, 3'b000);
                if (rom_loader_sck) checkOutput("sck_in_session", rom_loader_load, 1'b1);
                if (rom_loader_sck && sck_prev) checkOutput("data_stable", rom_loader_data, data_prev);
                if (rom_loader_sck && !sck_prev) begin
                    strobes++;
                    sck_rise_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_strobe: got strobe with data 0x%0h, required none", rom_loader_data);
                    end else begin
                        checkOutput("strobe_data", rom_loader_data, exp_q.pop_front());
                    end
                end
            end
            if (error && !err_prev) err_rise_cyc = cyc;
            sck_prev  = rom_loader_sck;
            err_prev  = error;
            data_prev = rom_loader_data;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {rom_loader_load, rom_loader_sck, done_loading, busy, error, rom_loader_data}, 21'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Happy path: two words
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        appendChecksum();
        expectWords(tx_q.size());
        strobes = 0;
        run = 1'b1;
        @(negedge clk);
        checkOutput("load_after_run", {rom_loader_load, busy}, 2'b11);
        applyStimulus(-1, tx_q.size());
        waitFor("happy_wait", 0, 400);
        checkOutput("happy_done", {done_loading, rom_loader_load, error}, 3'b100);
        checkOutput("happy_strobes", strobes, 2);
        checkOutput("happy_last_data", rom_loader_data, 16'hABCD);
        checkOutput("happy_queue_empty", exp_q.size(), 0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("happy_cleared", {done_loading, busy, rom_loader_load}, 3'b000);

        // Empty program
        tx_q = '{8'h00, 8'h00};
        appendChecksum();
        expectWords(tx_q.size());
        strobes = 0;
        run = 1'b1;
        @(negedge clk);
        checkOutput("empty_header_load", rom_loader_load, 1'b1);
        applyStimulus(-1, tx_q.size());
        waitFor("empty_wait", 0, 200);
        checkOutput("empty_done", {done_loading, rom_loader_load, busy, error}, 4'b1000);
        checkOutput("empty_strobes", strobes, 0);
        run = 1'b0;
        repeat (2) @(negedge clk);

        // Framing error on the third byte
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        appendChecksum();
        expectWords(2);
        strobes = 0;
        run = 1'b1;
        @(negedge clk);
        applyStimulus(2, 3);
        waitFor("frame_wait", 1, 100);
        checkOutput("frame_error", {error, rom_loader_load, rom_loader_sck, done_loading}, 4'b1000);
        checkOutput("frame_strobes", strobes, 0);
        run = 1'b0;
        @(negedge clk);
        checkOutput("frame_cleared", {error, busy, rom_loader_load}, 3'b000);
        @(negedge clk);

        // Ack never returns on the first word
        ack_enable = 1'b0;
        tx_q = '{8'h00, 8'h01, 8'h12, 8'h34};
        appendChecksum();
        expectWords(tx_q.size());
        strobes = 0;
        run = 1'b1;
        @(negedge clk);
        applyStimulus(-1, tx_q.size());
        waitFor("timeout_wait", 1, 300);
        @(negedge clk);
        checkOutput("timeout_latency", err_rise_cyc - sck_rise_cyc, ACK_TO + 1);
        checkOutput("timeout_outputs", {error, rom_loader_sck, rom_loader_load}, 3'b100);
        checkOutput("timeout_strobes", strobes, 1);
        run = 1'b0;
        ack_enable = 1'b1;
        repeat (2) @(negedge clk);

        // Abort while word 1 of 3 waits for its low byte
        tx_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h56, 8'h78};
        expectWords(3);
        strobes = 0;
        run = 1'b1;
        @(negedge clk);
        applyStimulus(-1, 3);
        checkOutput("abort_busy_before", busy, 1'b1);
        run = 1'b0;
        @(negedge clk);
        checkOutput("abort_outputs", {rom_loader_load, rom_loader_sck, busy, error}, 4'b0000);
        checkOutput("abort_strobes", strobes, 0);
        repeat (2) @(negedge clk);

        // Asynchronous reset while sck is high
        ack_enable = 1'b0;
        tx_q = '{8'h00, 8'h01, 8'h56, 8'h78};
        expectWords(tx_q.size());
        run = 1'b1;
        @(negedge clk);
        applyStimulus(-1, 4);
        waitFor("reset_sck_wait", 2, 100);
        checkOutput("reset_strobe_data", rom_loader_data, 16'h5678);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_async", {rom_loader_load, rom_loader_sck, done_loading, busy, error, rom_loader_data}, 21'h0);
        run = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ack_enable = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_idle", {rom_loader_load, busy, error, done_loading}, 4'b0000);

`ifdef UART_LOADER_CHECKSUM_EN
        // Checksum covers count and word bytes: 00^01^12^34 = 27
        tx_q = '{8'h00, 8'h01, 8'h12, 8'h34};
        appendChecksum();
        checkOutput("checksum_model", tx_q[4], 8'h27);
        expectWords(tx_q.size());
        strobes = 0;
        run = 1'b1;
        @(negedge clk);
        applyStimulus(-1, tx_q.size());
        waitFor("chk_good_wait", 0, 200);
        checkOutput("chk_good", {done_loading, error}, 2'b10);
        checkOutput("chk_good_strobes", strobes, 1);
        run = 1'b0;
        repeat (2) @(negedge clk);

        tx_q[4] = 8'h26;
        expectWords(tx_q.size());
        strobes = 0;
        run = 1'b1;
        @(negedge clk);
        applyStimulus(-1, tx_q.size());
        waitFor("chk_bad_wait", 1, 200);
        checkOutput("chk_bad", {error, done_loading, rom_loader_load}, 3'b100);
        checkOutput("chk_bad_strobes", strobes, 1);
        run = 1'b0;
        repeat (2) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
